i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx_if.sv | 20 ++
 rtl/i2s_rx.sv | 107 ++++++++++
 tb/tb_i2s_rx.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
// I2S receiver bus: serial inputs from the external codec plus the parallel sample outputs.
interface i2s_rx_if #(parameter int BIT_DEPTH = 8);
  logic                 bclk;
  logic                 lrclk;
  logic                 sdata;
  logic [BIT_DEPTH-1:0] audio_l;
  logic [BIT_DEPTH-1:0] audio_r;
  logic                 sample_valid;
  logic                 frame_err;

  modport master (
    output bclk, lrclk, sdata,
    input  audio_l, audio_r, sample_valid, frame_err
  );

  modport slave (
    input  bclk, lrclk, sdata,
    output audio_l, audio_r, sample_valid, frame_err
  );
endinterface

// File: rtl/i2s_rx.sv
// Philips I2S receiver, oversampling bclk/lrclk/sdata in the clk domain.
// HUNT waits for an lrclk 1->0 change; LEFT/RIGHT shift in words and pair them.
module i2s_rx #(
  parameter int BIT_DEPTH = 8
) (
  input logic     clk,
  input logic     reset,
  i2s_rx_if.slave bus
);
  localparam int CW = $clog2(BIT_DEPTH + 1);

  typedef enum logic [1:0] {HUNT = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;

  state_t               state_q;
  logic [1:0]           bclk_sync_q, lr_sync_q, sd_sync_q;
  logic                 bclk_prev_q, lr_prev_q, left_ok_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIT_DEPTH-1:0] shift_q, shift_d, hold_q, audio_l_q, audio_r_q;
  logic                 sample_valid_q, frame_err_q;
  logic                 strobe, lr_s, lr_chg, take_bit, word_done, short_word;

  assign strobe     = bclk_sync_q[1] & ~bclk_prev_q;
  assign lr_s       = lr_sync_q[1];
  assign lr_chg     = lr_s ^ lr_prev_q;
  assign take_bit   = (state_q != HUNT) && (cnt_q < CW'(BIT_DEPTH));
  assign shift_d    = {shift_q[BIT_DEPTH-2:0], sd_sync_q[1]};
  assign cnt_d      = cnt_q + CW'(1);
  // The strobe carrying an lrclk change also carries the LSB of the word just ending.
  assign word_done  = take_bit && (cnt_q == CW'(BIT_DEPTH - 1));
  assign short_word = (state_q != HUNT) && lr_chg && (cnt_q < CW'(BIT_DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], bus.bclk};
      lr_sync_q   <= {lr_sync_q[0], bus.lrclk};
      sd_sync_q   <= {sd_sync_q[0], bus.sdata};
      bclk_prev_q <= bclk_sync_q[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= HUNT;
      lr_prev_q      <= 1'b0;
      left_ok_q      <= 1'b0;
      cnt_q          <= '0;
      shift_q        <= '0;
      hold_q         <= '0;
      audio_l_q      <= '0;
      audio_r_q      <= '0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      if (strobe) begin
        lr_prev_q <= lr_s;
        if (take_bit) begin
          shift_q <= shift_d;
          cnt_q   <= cnt_d;
        end
        if (word_done) begin
          case (state_q)
            LEFT: begin
              hold_q    <= shift_d;
              left_ok_q <= 1'b1;
            end
            RIGHT: begin
              if (left_ok_q) begin
                audio_l_q      <= hold_q;
                audio_r_q      <= shift_d;
                sample_valid_q <= 1'b1;
                left_ok_q      <= 1'b0;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (short_word) begin
          frame_err_q <= 1'b1;
          left_ok_q   <= 1'b0;
        end
        if (lr_chg) begin
          if (state_q != HUNT) begin
            state_q <= lr_s ? RIGHT : LEFT;
            cnt_q   <= '0;
          end else if (!lr_s) begin
            state_q <= LEFT;
            cnt_q   <= '0;
          end
        end
      end
    end
  end

  assign bus.audio_l      = audio_l_q;
  assign bus.audio_r      = audio_r_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.frame_err    = frame_err_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Directed/randomized bench for i2s_rx: Philips I2S streams scored against a queue-based word model.
module tb_i2s_rx;
  localparam int BD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  i2s_rx_if #(.BIT_DEPTH(BD)) bus ();
  i2s_rx #(.BIT_DEPTH(BD)) dut (.clk(clk), .reset(rst), .bus(bus));

  always #10 clk = ~clk;

  // reference model state
  bit          m_locked, m_phase, m_prev, m_lok;
  logic [7:0]  m_hold, m_al, m_ar;
  bit          m_bits[$];
  int          m_sv_cnt = 0, m_err_cnt = 0, mon_sv = 0, mon_err = 0;
  logic        prev_sv = 1'b0, prev_err = 1'b0;

  // stimulus stream
  logic lr_q[$];
  logic sd_q[$];
  bit   carry_v = 0;
  logic carry_b = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_phase = 0; m_prev = 0; m_lok = 0;
    m_hold = '0; m_al = '0; m_ar = '0;
    m_bits.delete();
  endtask

  task automatic model_step(input logic lv, input logic b, output logic esv, output logic eerr);
    logic       chg;
    logic [7:0] w;
    esv = 1'b0; eerr = 1'b0;
    chg = (lv != m_prev);
    m_prev = lv;
    if (m_locked) begin
      if (m_bits.size() < BD) begin
        m_bits.push_back(b);
        if (m_bits.size() == BD) begin
          w = '0;
          foreach (m_bits[i]) w = {w[6:0], m_bits[i]};
          if (!m_phase) begin
            m_hold = w; m_lok = 1;
          end else if (m_lok) begin
            m_al = m_hold; m_ar = w; m_lok = 0; esv = 1'b1;
          end else begin
            eerr = 1'b1;
          end
        end
      end
      if (chg) begin
        if (m_bits.size() < BD) begin
          eerr = 1'b1; m_lok = 0;
        end
        m_phase = lv;
        m_bits.delete();
      end
    end else if (chg && !lv) begin
      m_locked = 1; m_phase = 0;
      m_bits.delete();
    end
    m_sv_cnt  += int'(esv);
    m_err_cnt += int'(eerr);
  endtask

  // Append one lrclk phase of h bclks; word bits sit at edges 1..nb, edge h spills into the next phase.
  task automatic push_phase(input logic lv, input logic [7:0] w, input int h, input int nb);
    int base;
    base = lr_q.size();
    for (int k = 0; k < h; k++) begin
      lr_q.push_back(lv);
      sd_q.push_back(1'($urandom));
    end
    if (carry_v) sd_q[base] = carry_b;
    carry_v = 0;
    for (int k = 1; k <= nb; k++) begin
      if (base + k < lr_q.size()) sd_q[base + k] = w[BD - k];
      else begin
        carry_v = 1; carry_b = w[BD - k];
      end
    end
  endtask

  task automatic push_pair(input logic [7:0] l, input logic [7:0] r, input int h);
    push_phase(1'b0, l, h, (h < BD) ? h : BD);
    push_phase(1'b1, r, h, (h < BD) ? h : BD);
  endtask

  task automatic play_entry(input logic lv, input logic b);
    logic [7:0] al0, ar0;
    logic       esv, eerr;
    bit         live;
    bus.lrclk = lv;
    bus.sdata = b;
    repeat ($urandom_range(3, 8)) @(negedge clk);
    bus.bclk = 1'b1;
    live = !rst;
    al0 = m_al; ar0 = m_ar; esv = 1'b0; eerr = 1'b0;
    if (live) model_step(lv, b, esv, eerr);
    @(negedge clk);
    @(negedge clk);
    if (live) begin
      chk("sv_early", bus.sample_valid, 0);
      chk("err_early", bus.frame_err, 0);
      chk("audio_l_hold", bus.audio_l, al0);
      chk("audio_r_hold", bus.audio_r, ar0);
    end
    @(negedge clk);
    if (live) begin
      chk("sample_valid", bus.sample_valid, esv);
      chk("frame_err", bus.frame_err, eerr);
      chk("audio_l", bus.audio_l, m_al);
      chk("audio_r", bus.audio_r, m_ar);
    end
    @(negedge clk);
    if (live) begin
      chk("sv_late", bus.sample_valid, 0);
      chk("err_late", bus.frame_err, 0);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.bclk = 1'b0;
  endtask

  task automatic play_range(input int i0, input int i1);
    for (int i = i0; i <= i1 && i < lr_q.size(); i++) play_entry(lr_q[i], sd_q[i]);
  endtask

  task automatic clear_stream();
    lr_q.delete(); sd_q.delete(); carry_v = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.bclk = 1'b0;
    @(negedge clk);
    chk("rst_audio_l", bus.audio_l, 0);
    chk("rst_audio_r", bus.audio_r, 0);
    chk("rst_sv", bus.sample_valid, 0);
    chk("rst_err", bus.frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sample_valid === 1'b1) mon_sv++;
      if (bus.frame_err === 1'b1) mon_err++;
      if (bus.sample_valid || bus.frame_err) begin
        chk("sv_err_overlap", bus.sample_valid & bus.frame_err, 0);
        chk("sv_consecutive", bus.sample_valid & prev_sv, 0);
        chk("err_consecutive", bus.frame_err & prev_err, 0);
      end
    end
    prev_sv  = bus.sample_valid;
    prev_err = bus.frame_err;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_sv, base_err;
    bus.bclk = 1'b0; bus.lrclk = 1'b0; bus.sdata = 1'b0;
    model_reset();
    do_reset();

    // 16 bclk frames, fixed A5/3C
    base_err = m_err_cnt;
    clear_stream();
    push_phase(1'b1, 8'h00, 8, 0);
    repeat (3) push_pair(8'hA5, 8'h3C, 8);
    push_phase(1'b0, 8'h00, 3, 0);
    play_range(0, lr_q.size() - 1);
    chk("a5_3c_l", bus.audio_l, 8'hA5);
    chk("a5_3c_r", bus.audio_r, 8'h3C);
    chk("a5_3c_no_err", m_err_cnt - base_err, 0);

    // random words, 16 bclk frames
    do_reset();
    clear_stream();
    push_phase(1'b1, 8'h00, 8, 0);
    repeat (4) push_pair(8'($urandom), 8'($urandom), 8);
    push_phase(1'b0, 8'h00, 3, 0);
    play_range(0, lr_q.size() - 1);

    // 32 bclk frames with padding
    do_reset();
    clear_stream();
    push_phase(1'b1, 8'h00, 16, 0);
    push_pair(8'h81, 8'h7E, 16);
    push_pair(8'($urandom), 8'($urandom), 16);
    push_phase(1'b0, 8'h00, 3, 0);
    play_range(0, 49);
    chk("pad_l", bus.audio_l, 8'h81);
    chk("pad_r", bus.audio_r, 8'h7E);
    play_range(50, lr_q.size() - 1);

    // short left word after 5 bits, then a clean 11/22 frame
    do_reset();
    clear_stream();
    push_phase(1'b1, 8'h00, 8, 0);
    push_pair(8'h99, 8'h66, 8);
    push_phase(1'b0, 8'hF0, 6, 5);
    push_phase(1'b1, 8'($urandom), 8, 8);
    push_pair(8'h11, 8'h22, 8);
    push_phase(1'b0, 8'h00, 3, 0);
    base_sv = m_sv_cnt;
    base_err = m_err_cnt;
    play_range(0, 24);
    chk("pre_short_l", bus.audio_l, 8'h99);
    play_range(25, 38);
    chk("short_err_seen", (m_err_cnt - base_err) > 0, 1);
    chk("short_no_sv", m_sv_cnt - base_sv, 1);
    play_range(39, lr_q.size() - 1);
    chk("after_short_l", bus.audio_l, 8'h11);
    chk("after_short_r", bus.audio_r, 8'h22);

    // reset released while lrclk = 1 mid right word
    clear_stream();
    push_phase(1'b1, 8'($urandom), 8, 8);
    push_pair(8'h5A, 8'hC3, 8);
    push_phase(1'b0, 8'h00, 3, 0);
    @(negedge clk);
    rst = 1'b1;
    play_range(0, 3);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    play_range(4, lr_q.size() - 1);
    chk("post_rst_l", bus.audio_l, 8'h5A);
    chk("post_rst_r", bus.audio_r, 8'hC3);

    // 2-clk reset in the middle of a right word
    clear_stream();
    push_phase(1'b1, 8'h00, 8, 0);
    push_pair(8'hE7, 8'h18, 8);
    push_pair(8'($urandom), 8'($urandom), 8);
    push_phase(1'b0, 8'h00, 3, 0);
    play_range(0, 35);
    chk("pre_mid_rst_l", bus.audio_l, 8'hE7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_l", bus.audio_l, 0);
    chk("mid_rst_r", bus.audio_r, 0);
    chk("mid_rst_sv", bus.sample_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    base_sv = m_sv_cnt;
    play_range(36, lr_q.size() - 1);
    chk("no_stale_sv", m_sv_cnt - base_sv, 0);
    clear_stream();
    push_phase(1'b1, 8'h00, 8, 0);
    push_pair(8'h3D, 8'hB2, 8);
    push_phase(1'b0, 8'h00, 3, 0);
    play_range(0, lr_q.size() - 1);
    chk("recover_l", bus.audio_l, 8'h3D);
    chk("recover_r", bus.audio_r, 8'hB2);

    repeat (4) @(negedge clk);
    chk("total_sv", mon_sv, m_sv_cnt);
    chk("total_err", mon_err, m_err_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
